// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet receive frame sequencer.
package ethernet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DISCARD
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          HEADER_BITS   = 112;
    localparam int          HEADER_BYTES  = HEADER_BITS / 8;
    localparam int          MIN_PAYLOAD   = 46;
    localparam int          FCS_BYTES     = 4;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // Alternating bits required before the closing "11" of the SFD is trusted.
    localparam logic [5:0]  SFD_MIN_ALT   = 6'd14;

    function automatic logic [5:0] sat_inc6(input logic [5:0] value);
        return (value == 6'h3F) ? value : value + 6'd1;
    endfunction

endpackage

// File: rtl/ethernet_byte_assembler.sv
// LSB-first serial-to-byte assembler; completion and the finished byte are
// presented combinationally on the strobe that carries the 8th bit.
module ethernet_byte_assembler (
    input  logic       clk,
    input  logic       srst,
    input  logic       clear,
    input  logic       bit_strobe,
    input  logic       bit_in,
    output logic       byte_complete,
    output logic [7:0] byte_value,
    output logic [2:0] bit_count
);

    logic [7:0] shift_reg;
    logic [2:0] count_reg;

    assign byte_value    = {bit_in, shift_reg[7:1]};
    assign byte_complete = bit_strobe && (count_reg == 3'd7);
    assign bit_count     = count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else if (bit_strobe) begin
            shift_reg <= byte_value;
            count_reg <= count_reg + 3'd1;
        end
    end

endmodule

// File: rtl/ethernet_rx_frame_ctrl.sv
// Ethernet receive frame sequencer: preamble/SFD lock, header capture and
// destination filtering, payload streaming with one-byte holdback.
module ethernet_rx_frame_ctrl
    import ethernet_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bit_valid,
    input  logic        i_bit,
    input  logic        i_carrier,
    input  logic        i_promisc,
    output logic        o_hdr_valid,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_ethertype,
    output logic        o_byte_valid,
    output logic [7:0]  o_byte,
    output logic        o_byte_last,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_drop
);

    localparam logic [11:0] OVERSIZE_COUNT  = 12'(MAX_PAYLOAD + FCS_BYTES + 1);
    localparam logic [10:0] MIN_FRAME_COUNT = 11'(MIN_PAYLOAD + FCS_BYTES);
    localparam logic [3:0]  LAST_HDR_BYTE   = 4'(HEADER_BYTES - 1);

    state_t        state_reg, state_next;
    logic [5:0]    alt_reg, alt_next;
    logic          prev_bit_reg, prev_bit_next;
    logic [3:0]    hdr_cnt_reg, hdr_cnt_next;
    logic [103:0]  hdr_shift_reg, hdr_shift_next;
    logic [7:0]    hold_reg, hold_next;
    logic          hold_valid_reg, hold_valid_next;
    logic [10:0]   byte_cnt_reg, byte_cnt_next;
    logic [47:0]   dst_reg, dst_next;
    logic [47:0]   src_reg, src_next;
    logic [15:0]   type_reg, type_next;
    logic          hdr_valid_reg, hdr_valid_next;
    logic          drop_reg, drop_next;
    logic          byte_valid_reg, byte_valid_next;
    logic [7:0]    byte_reg, byte_next;
    logic          last_reg, last_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic          bit_taken;
    logic          in_bytes;
    logic          asm_complete;
    logic [7:0]    asm_byte;
    logic [2:0]    asm_bit_count;
    logic [111:0]  full_header;
    logic [47:0]   dst_in;
    logic          dst_accept;
    logic [11:0]   byte_count_inc;

    assign bit_taken      = i_bit_valid && i_carrier;
    assign in_bytes       = (state_reg == HEADER) || (state_reg == PAYLOAD);
    assign full_header    = {hdr_shift_reg, asm_byte};
    assign dst_in         = full_header[111:64];
    assign dst_accept     = (dst_in == MAC_ADDR) || (dst_in == BROADCAST_MAC) || i_promisc;
    assign byte_count_inc = {1'b0, byte_cnt_reg} + 12'd1;

    ethernet_byte_assembler u_assembler (
        .clk           (i_clk),
        .srst          (i_rst),
        .clear         (!in_bytes),
        .bit_strobe    (bit_taken && in_bytes),
        .bit_in        (i_bit),
        .byte_complete (asm_complete),
        .byte_value    (asm_byte),
        .bit_count     (asm_bit_count)
    );

    always_comb begin
        state_next      = state_reg;
        alt_next        = alt_reg;
        prev_bit_next   = prev_bit_reg;
        hdr_cnt_next    = hdr_cnt_reg;
        hdr_shift_next  = hdr_shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        byte_cnt_next   = byte_cnt_reg;
        dst_next        = dst_reg;
        src_next        = src_reg;
        type_next       = type_reg;
        byte_next       = byte_reg;
        hdr_valid_next  = 1'b0;
        drop_next       = 1'b0;
        byte_valid_next = 1'b0;
        last_next       = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bit_taken) begin
                    state_next    = PREAMBLE;
                    alt_next      = 6'd1;
                    prev_bit_next = i_bit;
                end
            end
            PREAMBLE: begin
                if (!i_carrier) begin
                    state_next = IDLE;
                end else if (i_bit_valid) begin
                    prev_bit_next = i_bit;
                    if (i_bit == prev_bit_reg) begin
                        if (i_bit && (alt_reg >= SFD_MIN_ALT)) begin
                            state_next   = HEADER;
                            hdr_cnt_next = '0;
                        end else begin
                            state_next = DISCARD;
                        end
                    end else begin
                        alt_next = sat_inc6(alt_reg);
                    end
                end
            end
            HEADER: begin
                if (!i_carrier) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (asm_complete) begin
                    hdr_shift_next = full_header[103:0];
                    hdr_cnt_next   = hdr_cnt_reg + 4'd1;
                    if (hdr_cnt_reg == LAST_HDR_BYTE) begin
                        dst_next  = full_header[111:64];
                        src_next  = full_header[63:16];
                        type_next = full_header[15:0];
                        if (dst_accept) begin
                            hdr_valid_next  = 1'b1;
                            state_next      = PAYLOAD;
                            byte_cnt_next   = '0;
                            hold_valid_next = 1'b0;
                        end else begin
                            drop_next  = 1'b1;
                            state_next = DISCARD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!i_carrier) begin
                    // End of frame: flush holdback and report exactly one status.
                    byte_valid_next = hold_valid_reg;
                    byte_next       = hold_valid_reg ? hold_reg : byte_reg;
                    last_next       = hold_valid_reg;
                    if ((asm_bit_count != 3'd0) || (byte_cnt_reg < MIN_FRAME_COUNT)) begin
                        err_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                    hold_valid_next = 1'b0;
                    state_next      = IDLE;
                end else if (asm_complete) begin
                    if (byte_count_inc == OVERSIZE_COUNT) begin
                        // Oversize: the byte just completed is discarded.
                        byte_valid_next = 1'b1;
                        byte_next       = hold_reg;
                        last_next       = 1'b1;
                        err_next        = 1'b1;
                        hold_valid_next = 1'b0;
                        state_next      = DISCARD;
                    end else begin
                        byte_valid_next = hold_valid_reg;
                        byte_next       = hold_valid_reg ? hold_reg : byte_reg;
                        hold_next       = asm_byte;
                        hold_valid_next = 1'b1;
                        byte_cnt_next   = byte_count_inc[10:0];
                    end
                end
            end
            DISCARD: begin
                if (!i_carrier) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            alt_reg        <= '0;
            prev_bit_reg   <= 1'b0;
            hdr_cnt_reg    <= '0;
            hdr_shift_reg  <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            byte_cnt_reg   <= '0;
            dst_reg        <= '0;
            src_reg        <= '0;
            type_reg       <= '0;
            hdr_valid_reg  <= 1'b0;
            drop_reg       <= 1'b0;
            byte_valid_reg <= 1'b0;
            byte_reg       <= '0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            alt_reg        <= alt_next;
            prev_bit_reg   <= prev_bit_next;
            hdr_cnt_reg    <= hdr_cnt_next;
            hdr_shift_reg  <= hdr_shift_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            byte_cnt_reg   <= byte_cnt_next;
            dst_reg        <= dst_next;
            src_reg        <= src_next;
            type_reg       <= type_next;
            hdr_valid_reg  <= hdr_valid_next;
            drop_reg       <= drop_next;
            byte_valid_reg <= byte_valid_next;
            byte_reg       <= byte_next;
            last_reg       <= last_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    assign o_hdr_valid  = hdr_valid_reg;
    assign o_dst_mac    = dst_reg;
    assign o_src_mac    = src_reg;
    assign o_ethertype  = type_reg;
    assign o_byte_valid = byte_valid_reg;
    assign o_byte       = byte_reg;
    assign o_byte_last  = last_reg;
    assign o_frame_done = done_reg;
    assign o_frame_err  = err_reg;
    assign o_drop       = drop_reg;

endmodule

// File: tb/tb_ethernet_rx_frame_ctrl.sv
// Scoreboard bench for ethernet_rx_frame_ctrl: expected events are queued as
// frames are driven and matched against DUT output pulses.
`timescale 1ns/1ps
module tb_ethernet_rx_frame_ctrl;
    import ethernet_pkg::*;

    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC  = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] BCST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] FOREIGN = 48'h112233445566;
    localparam int MAXP = 1500;

    localparam int K_HDR  = 1;
    localparam int K_DROP = 2;
    localparam int K_BYTE = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_bit_valid = 1'b0;
    logic        i_bit = 1'b0;
    logic        i_carrier = 1'b0;
    logic        i_promisc = 1'b0;
    logic        o_hdr_valid;
    logic [47:0] o_dst_mac;
    logic [47:0] o_src_mac;
    logic [15:0] o_ethertype;
    logic        o_byte_valid;
    logic [7:0]  o_byte;
    logic        o_byte_last;
    logic        o_frame_done;
    logic        o_frame_err;
    logic        o_drop;

    always #5 i_clk = ~i_clk;

    ethernet_rx_frame_ctrl #(
        .MAC_ADDR    (MAC),
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_bit_valid  (i_bit_valid),
        .i_bit        (i_bit),
        .i_carrier    (i_carrier),
        .i_promisc    (i_promisc),
        .o_hdr_valid  (o_hdr_valid),
        .o_dst_mac    (o_dst_mac),
        .o_src_mac    (o_src_mac),
        .o_ethertype  (o_ethertype),
        .o_byte_valid (o_byte_valid),
        .o_byte       (o_byte),
        .o_byte_last  (o_byte_last),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err),
        .o_drop       (o_drop)
    );

    typedef struct {
        int           kind;
        logic [111:0] data;
    } evt_t;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   gap_mode = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [111:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [111:0] data);
        evt_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 112'(kind), 112'd0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 112'(kind), 112'(e.kind));
            check("event_data", data, e.data);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_hdr_valid)  observe(K_HDR, {o_dst_mac, o_src_mac, o_ethertype});
            if (o_drop)       observe(K_DROP, '0);
            if (o_byte_valid) observe(K_BYTE, {103'd0, o_byte_last, o_byte});
            if (o_frame_done) observe(K_DONE, '0);
            if (o_frame_err)  observe(K_ERR, '0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_hdr_valid"}, 112'(o_hdr_valid), 112'd0);
        check({tag, "_dst"},       112'(o_dst_mac), 112'd0);
        check({tag, "_src"},       112'(o_src_mac), 112'd0);
        check({tag, "_type"},      112'(o_ethertype), 112'd0);
        check({tag, "_byte_valid"},112'(o_byte_valid), 112'd0);
        check({tag, "_byte"},      112'(o_byte), 112'd0);
        check({tag, "_last"},      112'(o_byte_last), 112'd0);
        check({tag, "_done"},      112'(o_frame_done), 112'd0);
        check({tag, "_err"},       112'(o_frame_err), 112'd0);
        check({tag, "_drop"},      112'(o_drop), 112'd0);
    endtask

    task automatic send_bit(input logic b);
        if (gap_mode) begin
            while ($urandom_range(0, 1) == 1) begin
                i_bit_valid = 1'b0;
                i_bit = 1'($urandom);
                @(posedge i_clk);
                #1;
            end
        end
        i_bit_valid = 1'b1;
        i_bit = b;
        @(posedge i_clk);
        #1;
        i_bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_header(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] etype);
        i_carrier = 1'b1;
        repeat (7) send_byte(PREAMBLE_BYTE);
        send_byte(SFD_BYTE);
        for (int i = 0; i < 6; i++) send_byte(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) send_byte(src[47 - 8*i -: 8]);
        send_byte(etype[15:8]);
        send_byte(etype[7:0]);
    endtask

    task automatic run_frame(input string name, input logic [47:0] dst, input logic [15:0] etype,
                             input int nbytes, input int extra_bits, input logic promisc);
        bit accept;
        bit err;
        int nout;
        accept = (dst == MAC) || (dst == BCST) || promisc;
        i_promisc = promisc;
        if (accept) begin
            push(K_HDR, {dst, SRC, etype});
            if (nbytes >= MAXP + 5) begin
                nout = MAXP + 4;
                err = 1'b1;
            end else begin
                nout = nbytes;
                err = (extra_bits != 0) || (nbytes < 50);
            end
            for (int i = 0; i < nout; i++) push(K_BYTE, {103'd0, (i == nout - 1), 8'(i)});
            push(err ? K_ERR : K_DONE, '0);
        end else begin
            push(K_DROP, '0);
        end
        send_header(dst, SRC, etype);
        for (int i = 0; i < nbytes; i++) send_byte(8'(i));
        for (int i = 0; i < extra_bits; i++) send_bit(1'((i + 1) & 1));
        i_carrier = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        check({name, "_drained"}, 112'(exp_q.size()), 112'd0);
        if (accept) check({name, "_dst_hold"}, 112'(o_dst_mac), 112'(dst));
        $display("frame %s: dst=%h bytes=%0d extra_bits=%0d promisc=%0d accept=%0d",
                 name, dst, nbytes, extra_bits, promisc, accept);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;

        run_frame("basic", MAC, 16'h0800, 50, 0, 1'b0);
        run_frame("filtered", FOREIGN, 16'h0800, 50, 0, 1'b0);
        run_frame("promisc", FOREIGN, 16'h0800, 50, 0, 1'b1);
        run_frame("broadcast", BCST, 16'h86DD, 50, 0, 1'b0);
        gap_mode = 1'b1;
        run_frame("gapped", MAC, 16'h0800, 50, 0, 1'b0);
        gap_mode = 1'b0;
        run_frame("misaligned", MAC, 16'h0800, 60, 3, 1'b0);
        run_frame("runt", MAC, 16'h0800, 20, 0, 1'b0);
        run_frame("oversize", MAC, 16'h0800, 1510, 0, 1'b0);

        // Reset in the middle of a payload: only bytes already emitted count.
        push(K_HDR, {MAC, SRC, 16'h0800});
        for (int i = 0; i < 9; i++) push(K_BYTE, {103'd0, 1'b0, 8'(i)});
        send_header(MAC, SRC, 16'h0800);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_carrier = 1'b0;
        check_all_zero("midreset");
        repeat (3) @(posedge i_clk);
        #1;
        check("midreset_drained", 112'(exp_q.size()), 112'd0);
        $display("frame midreset: reset after 10 payload bytes");
        exp_q.delete();
        run_frame("after_reset", MAC, 16'h0800, 50, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
